// File: rtl/blur_frame_scheduler.sv
// Round-robin scheduler sharing one blur engine between two frame requesters.
// Define BLUR_SCHED_TIMEOUT_EN to build the WAIT_DONE watchdog (drives err).
module blur_frame_scheduler #(
   parameter int unsigned WIDTH          = 20,
   parameter int unsigned HEIGHT         = 12,
   parameter int unsigned OUT_LAT        = 1,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [7:0] src_data_0,
   input  logic [7:0] src_data_1,
   output logic [1:0] src_rd,
   output logic [1:0] grant,
   output logic       eng_rst,
   output logic       eng_start,
   output logic [7:0] eng_data,
   input  logic       eng_done,
   input  logic [7:0] eng_out,
   output logic       dst_valid,
   output logic [7:0] dst_data,
   output logic       dst_id,
   output logic       busy,
   output logic       err
);

   localparam int unsigned N         = WIDTH * HEIGHT * 3;
   localparam int unsigned CNT_MAX_A = (N > TIMEOUT_CYCLES) ? N : TIMEOUT_CYCLES;
   localparam int unsigned CNT_MAX   = (CNT_MAX_A > OUT_LAT) ? CNT_MAX_A : OUT_LAT;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
   localparam int unsigned SKIP_LAST = (OUT_LAT > 1) ? OUT_LAT - 2 : 0;

   typedef enum logic [2:0] {
      IDLE,
      ENG_RST,
      START,
      LOAD,
      WAIT_DONE,
      SKIP,
      UNLOAD
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic             pick;

   // Requester chosen in IDLE: on a tie, the one not served last
   always_comb begin
      pick = 1'b0;
      if (req == 2'b11) pick = ~last;
      else if (req[1]) pick = 1'b1;
   end

   // Byte paths are gated passthroughs so each byte lines up with its strobe
   assign eng_data = src_rd[1] ? src_data_1 : (src_rd[0] ? src_data_0 : 8'h00);
   assign dst_data = dst_valid ? eng_out : 8'h00;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         last      <= 1'b1;
         grant     <= 2'b00;
         src_rd    <= 2'b00;
         eng_rst   <= 1'b0;
         eng_start <= 1'b0;
         dst_valid <= 1'b0;
         dst_id    <= 1'b0;
         busy      <= 1'b0;
`ifdef BLUR_SCHED_TIMEOUT_EN
         err       <= 1'b0;
`endif
      end else begin
         eng_rst   <= 1'b0;
         eng_start <= 1'b0;
`ifdef BLUR_SCHED_TIMEOUT_EN
         err       <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  state   <= ENG_RST;
                  grant   <= pick ? 2'b10 : 2'b01;
                  eng_rst <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            ENG_RST: begin
               state     <= START;
               eng_start <= 1'b1;
            end
            START: begin
               state  <= LOAD;
               cnt    <= '0;
               src_rd <= grant;
            end
            LOAD: begin
               if (cnt == CNT_W'(N - 1)) begin
                  state  <= WAIT_DONE;
                  cnt    <= '0;
                  src_rd <= 2'b00;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            WAIT_DONE: begin
               if (eng_done) begin
                  cnt <= '0;
                  if (OUT_LAT > 1) begin
                     state <= SKIP;
                  end else begin
                     state     <= UNLOAD;
                     dst_valid <= 1'b1;
                     dst_id    <= grant[1];
                     last      <= grant[1];
                  end
               end
`ifdef BLUR_SCHED_TIMEOUT_EN
               // Engine never finished: drop the frame and count it as served
               else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  err     <= 1'b1;
                  eng_rst <= 1'b1;
                  grant   <= 2'b00;
                  busy    <= 1'b0;
                  last    <= grant[1];
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
`endif
            end
            SKIP: begin
               if (cnt == CNT_W'(SKIP_LAST)) begin
                  state     <= UNLOAD;
                  cnt       <= '0;
                  dst_valid <= 1'b1;
                  dst_id    <= grant[1];
                  last      <= grant[1];
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            UNLOAD: begin
               if (cnt == CNT_W'(N - 1)) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  dst_valid <= 1'b0;
                  dst_id    <= 1'b0;
                  grant     <= 2'b00;
                  busy      <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef BLUR_SCHED_TIMEOUT_EN
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_blur_frame_scheduler.sv
// Directed bench for blur_frame_scheduler: instance a (OUT_LAT=1) and instance b
// (OUT_LAT=3, TIMEOUT_CYCLES=16), each with a source ramp and an XOR-5A engine model.
`timescale 1ns/1ps
module tb_blur_frame_scheduler;

   localparam int N = 720;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req       [2];
   logic [7:0] sd0       [2];
   logic [7:0] sd1       [2];
   logic [1:0] src_rd    [2];
   logic [1:0] grant     [2];
   logic       eng_rst   [2];
   logic       eng_start [2];
   logic [7:0] eng_data  [2];
   logic       eng_done  [2];
   logic [7:0] eng_out   [2];
   logic       dst_valid [2];
   logic [7:0] dst_data  [2];
   logic       dst_id    [2];
   logic       busy      [2];
   logic       err       [2];

   // bench models
   int         cyc;
   int         ptr0 [2], ptr1 [2], in_cnt [2], dly [2], oc [2];
   logic [7:0] mem  [2][N];
   logic       hold_done [2];
   logic       exp_id [2];
   logic       mon_clr;

   // monitor results
   int   n_rd0 [2], n_rd1 [2], n_rst [2], n_start [2], n_val [2], n_bad [2], n_err [2];
   int   n_frm [2], vk [2], first_lat [2], done_cyc [2], rst_cyc [2], start_cyc [2];
   int   first_rd_cyc [2], last_rd_cyc [2], err_cyc [2], first_val_cyc [2], last_val_cyc [2];
   int   id_log [2][8];
   logic done_prev [2], val_prev [2];
   logic [7:0] exp_in, exp_out;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   blur_frame_scheduler #(.WIDTH(20), .HEIGHT(12), .OUT_LAT(1), .TIMEOUT_CYCLES(4096)) dut_a (
      .clk(clk), .reset(reset), .req(req[0]), .src_data_0(sd0[0]), .src_data_1(sd1[0]),
      .src_rd(src_rd[0]), .grant(grant[0]), .eng_rst(eng_rst[0]), .eng_start(eng_start[0]),
      .eng_data(eng_data[0]), .eng_done(eng_done[0]), .eng_out(eng_out[0]),
      .dst_valid(dst_valid[0]), .dst_data(dst_data[0]), .dst_id(dst_id[0]),
      .busy(busy[0]), .err(err[0]));

   blur_frame_scheduler #(.WIDTH(20), .HEIGHT(12), .OUT_LAT(3), .TIMEOUT_CYCLES(16)) dut_b (
      .clk(clk), .reset(reset), .req(req[1]), .src_data_0(sd0[1]), .src_data_1(sd1[1]),
      .src_rd(src_rd[1]), .grant(grant[1]), .eng_rst(eng_rst[1]), .eng_start(eng_start[1]),
      .eng_data(eng_data[1]), .eng_done(eng_done[1]), .eng_out(eng_out[1]),
      .dst_valid(dst_valid[1]), .dst_data(dst_data[1]), .dst_id(dst_id[1]),
      .busy(busy[1]), .err(err[1]));

   function automatic int lat(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic logic [25:0] outs(input int i);
      return {grant[i], src_rd[i], eng_rst[i], eng_start[i], eng_data[i],
              dst_valid[i], dst_data[i], dst_id[i], busy[i], err[i]};
   endfunction

   // Sources: requester 0 ramps, requester 1 ramps inverted
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         sd0[i] = 8'(ptr0[i]);
         sd1[i] = ~8'(ptr1[i]);
      end
   end

   // Engine output: byte k appears lat cycles after done rise plus k
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         eng_out[i] = 8'h00;
         if (eng_done[i] === 1'b1 && oc[i] >= lat(i) && oc[i] - lat(i) < N)
            eng_out[i] = mem[i][oc[i] - lat(i)] ^ 8'h5A;
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (reset || eng_rst[i]) begin
            ptr0[i] <= 0; ptr1[i] <= 0; in_cnt[i] <= 0; dly[i] <= 0; oc[i] <= 0;
            eng_done[i] <= 1'b0;
         end else begin
            if (src_rd[i][0]) ptr0[i] <= ptr0[i] + 1;
            if (src_rd[i][1]) ptr1[i] <= ptr1[i] + 1;
            if (src_rd[i] != 2'b00 && in_cnt[i] < N) begin
               mem[i][in_cnt[i]] <= eng_data[i];
               in_cnt[i] <= in_cnt[i] + 1;
            end
            if (in_cnt[i] == N && !eng_done[i]) begin
               if (dly[i] == 4 && !hold_done[i]) eng_done[i] <= 1'b1;
               else if (dly[i] < 4) dly[i] <= dly[i] + 1;
            end
            if (eng_done[i]) oc[i] <= oc[i] + 1;
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mon_clr) begin
            n_rd0[i] = 0; n_rd1[i] = 0; n_rst[i] = 0; n_start[i] = 0; n_val[i] = 0;
            n_bad[i] = 0; n_err[i] = 0; n_frm[i] = 0; vk[i] = 0; first_lat[i] = -1;
            done_prev[i] = 1'b0; val_prev[i] = 1'b0;
         end else begin
            if (src_rd[i] != 2'b00) begin
               if (n_rd0[i] + n_rd1[i] == 0) first_rd_cyc[i] = cyc;
               last_rd_cyc[i] = cyc;
               if (src_rd[i][0]) n_rd0[i]++;
               if (src_rd[i][1]) n_rd1[i]++;
               exp_in = src_rd[i][1] ? ~8'(ptr1[i]) : 8'(ptr0[i]);
               if (eng_data[i] !== exp_in || src_rd[i] !== grant[i]) n_bad[i]++;
            end else if (eng_data[i] !== 8'h00) begin
               n_bad[i]++;
            end
            if (eng_rst[i]) begin n_rst[i]++; rst_cyc[i] = cyc; end
            if (eng_start[i]) begin n_start[i]++; start_cyc[i] = cyc; end
            if (eng_done[i] === 1'b1 && !done_prev[i]) done_cyc[i] = cyc;
            done_prev[i] = (eng_done[i] === 1'b1);
            if (dst_valid[i]) begin
               if (!val_prev[i]) begin
                  vk[i] = 0;
                  first_lat[i] = cyc - done_cyc[i];
                  first_val_cyc[i] = cyc;
                  if (n_frm[i] < 8) id_log[i][n_frm[i]] = int'(dst_id[i]);
                  n_frm[i]++;
               end
               last_val_cyc[i] = cyc;
               exp_out = (exp_id[i] ? ~8'(vk[i]) : 8'(vk[i])) ^ 8'h5A;
               if (dst_data[i] !== exp_out || dst_id[i] !== exp_id[i]) n_bad[i]++;
               vk[i]++;
               n_val[i]++;
            end else if (dst_data[i] !== 8'h00) begin
               n_bad[i]++;
            end
            val_prev[i] = dst_valid[i];
            if (err[i]) begin n_err[i]++; err_cyc[i] = cyc; end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clr();
      mon_clr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      mon_clr = 1'b0;
   endtask

   task automatic wait_busy(input int i, input string tag);
      int k = 0;
      while (busy[i] !== 1'b1 && k < 50) begin tick(); k++; end
      chk(tag, 32'(busy[i]), 1);
   endtask

   task automatic wait_idle(input int i, input string tag, input int budget);
      int k = 0;
      while (busy[i] !== 1'b0 && k < budget) begin tick(); k++; end
      chk(tag, 32'(busy[i]), 0);
   endtask

   initial begin
      reset = 1'b1;
      mon_clr = 1'b1;
      req[0] = 2'b00; req[1] = 2'b00;
      hold_done[0] = 1'b0; hold_done[1] = 1'b0;
      exp_id[0] = 1'b0; exp_id[1] = 1'b0;
      repeat (3) tick();
      chk("reset_outs_a", 32'(outs(0)), 0);
      chk("reset_outs_b", 32'(outs(1)), 0);
      reset = 1'b0;
      clr();

      // Single frame from requester 0
      req[0] = 2'b01;
      wait_busy(0, "a_busy");
      chk("a_grant", 32'(grant[0]), 1);
      req[0] = 2'b00;
      wait_idle(0, "a_idle", 3000);
      chk("a_eng_rst_cnt", n_rst[0], 1);
      chk("a_eng_start_cnt", n_start[0], 1);
      chk("a_start_after_rst", start_cyc[0] - rst_cyc[0], 1);
      chk("a_load_after_start", first_rd_cyc[0] - start_cyc[0], 1);
      chk("a_rd0_cnt", n_rd0[0], N);
      chk("a_rd1_cnt", n_rd1[0], 0);
      chk("a_valid_cnt", n_val[0], N);
      chk("a_valid_span", last_val_cyc[0] - first_val_cyc[0], N - 1);
      chk("a_latency", first_lat[0], 1);
      chk("a_id", id_log[0][0], 0);
      chk("a_bad_bytes", n_bad[0], 0);
      chk("a_err", n_err[0], 0);

      // Requester 1 drops req mid-LOAD
      clr();
      req[0] = 2'b10;
      exp_id[0] = 1'b1;
      wait_busy(0, "d_busy");
      chk("d_grant", 32'(grant[0]), 2);
      repeat (100) tick();
      chk("d_in_load", 32'(src_rd[0]), 2);
      req[0] = 2'b00;
      wait_idle(0, "d_idle", 3000);
      chk("d_rd1_cnt", n_rd1[0], N);
      chk("d_rd0_cnt", n_rd0[0], 0);
      chk("d_valid_cnt", n_val[0], N);
      chk("d_id", id_log[0][0], 1);
      chk("d_bad_bytes", n_bad[0], 0);

      // Reset while loading byte 300
      clr();
      req[0] = 2'b01;
      exp_id[0] = 1'b0;
      wait_busy(0, "r_busy");
      begin
         int k = 0;
         while (n_rd0[0] < 300 && k < 1000) begin tick(); k++; end
      end
      chk("r_reached_300", n_rd0[0], 300);
      reset = 1'b1;
      #1;
      chk("r_outs_zero", 32'(outs(0)), 0);
      req[0] = 2'b00;
      repeat (2) tick();
      reset = 1'b0;
      clr();
      repeat (20) tick();
      chk("r_no_valid", n_val[0], 0);
      chk("r_idle", 32'(busy[0]), 0);

      // Tie held for three frames after reset: 0,1,0
      req[0] = 2'b11;
      for (int f = 0; f < 3; f++) begin
         exp_id[0] = (f == 1);
         wait_busy(0, "t_busy");
         chk("t_grant", 32'(grant[0]), (f == 1) ? 2 : 1);
         if (f == 2) req[0] = 2'b00;
         wait_idle(0, "t_idle", 3000);
      end
      chk("t_frames", n_frm[0], 3);
      chk("t_id0", id_log[0][0], 0);
      chk("t_id1", id_log[0][1], 1);
      chk("t_id2", id_log[0][2], 0);
      chk("t_valid_cnt", n_val[0], 3 * N);
      chk("t_eng_rst_cnt", n_rst[0], 3);
      chk("t_bad_bytes", n_bad[0], 0);

      // OUT_LAT=3 instance
      clr();
      req[1] = 2'b01;
      exp_id[1] = 1'b0;
      wait_busy(1, "l_busy");
      req[1] = 2'b00;
      wait_idle(1, "l_idle", 3000);
      chk("l_latency", first_lat[1], 3);
      chk("l_valid_cnt", n_val[1], N);
      chk("l_valid_span", last_val_cyc[1] - first_val_cyc[1], N - 1);
      chk("l_bad_bytes", n_bad[1], 0);

      // Engine never finishes
      clr();
      hold_done[1] = 1'b1;
      req[1] = 2'b01;
      wait_busy(1, "w_busy");
      req[1] = 2'b00;
`ifdef BLUR_SCHED_TIMEOUT_EN
      begin
         int k = 0;
         while (err[1] !== 1'b1 && k < 3000) begin tick(); k++; end
      end
      chk("w_err", 32'(err[1]), 1);
      chk("w_err_delay", err_cyc[1] - (last_rd_cyc[1] + 1), 16);
      chk("w_idle", 32'(busy[1]), 0);
      chk("w_eng_rst", 32'(eng_rst[1]), 1);
      tick();
      chk("w_err_pulse", 32'(err[1]), 0);
      chk("w_err_cnt", n_err[1], 1);
      chk("w_no_valid", n_val[1], 0);
      chk("w_eng_rst_cnt", n_rst[1], 2);
      hold_done[1] = 1'b0;
      // timed-out requester 0 counts as served, so a tie goes to 1
      req[1] = 2'b11;
      exp_id[1] = 1'b1;
      wait_busy(1, "w2_busy");
      chk("w2_grant", 32'(grant[1]), 2);
      req[1] = 2'b00;
      wait_idle(1, "w2_idle", 3000);
      chk("w2_valid_cnt", n_val[1], N);
`else
      repeat (100) tick();
      chk("w_err", 32'(err[1]), 0);
      chk("w_still_busy", 32'(busy[1]), 1);
      chk("w_no_valid", n_val[1], 0);
      hold_done[1] = 1'b0;
      wait_idle(1, "w_idle", 3000);
      chk("w_valid_cnt", n_val[1], N);
      chk("w_err_cnt", n_err[1], 0);
      chk("w_bad_bytes", n_bad[1], 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
